// File: rtl/i2c_target_regfile.sv
// I2C target exposing REGCOUNT byte registers plus one external read-only byte.
// Bus lines are resynchronised; all protocol decisions use the synchronised copies.
module i2c_target_regfile #(
  parameter int unsigned REGCOUNT = 20,
  parameter logic [6:0]  DEVADDR  = 7'h42,
  parameter bit          AUTO_INC = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  input  logic [7:0]            parallel_in,
  output logic [8*REGCOUNT-1:0] registers_packed,
  output logic                  busy,
  output logic                  wr_strobe,
  output logic [7:0]            wr_index
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_e;

  localparam logic [7:0] LAST = 8'(REGCOUNT);

  logic [2:0] scl_q;
  logic [2:0] sda_q;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       wstb_q, wstb_d;
  logic [7:0] widx_q, widx_d;
  logic [7:0] wdat_q, wdat_d;

  logic [7:0] regs_q [REGCOUNT];

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall;
  logic       start, stop;
  logic       rx_state, rx_done;
  logic [7:0] ptr_inc;
  logic [7:0] rd_cur, rd_nxt;

  // [0],[1] synchroniser, [2] previous synchronised value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  assign scl_s    = scl_q[1];
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

  assign rx_state = (state_q == ADDR) || (state_q == PTR) ||
                    (state_q == WDATA);
  assign rx_done  = scl_fall && (cnt_q == 4'd8);

  // Pointer REGCOUNT is the last readable slot, so wrap after it
  always_comb begin
    ptr_inc = ptr_q;
    if (AUTO_INC) begin
      ptr_inc = (ptr_q >= LAST) ? 8'h00 : ptr_q + 8'h01;
    end
  end

  always_comb begin
    rd_cur = 8'h00;
    rd_nxt = 8'h00;
    if (ptr_q == LAST) rd_cur = parallel_in;
    if (ptr_inc == LAST) rd_nxt = parallel_in;
    for (int i = 0; i < int'(REGCOUNT); i++) begin
      if (ptr_q == 8'(i)) rd_cur = regs_q[i];
      if (ptr_inc == 8'(i)) rd_nxt = regs_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    ack_d   = ack_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    wstb_d  = 1'b0;
    widx_d  = widx_q;
    wdat_d  = wdat_q;
    if (start) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      if (rx_state && scl_rise) begin
        sh_d  = {sh_q[6:0], sda_s};
        cnt_d = cnt_q + 4'd1;
      end
      unique case (state_q)
        IDLE: begin
          oe_d = 1'b0;
        end
        ADDR: begin
          if (rx_done) begin
            cnt_d = 4'd0;
            if (sh_q[7:1] == DEVADDR) begin
              state_d = ADDR_ACK;
              oe_d    = 1'b1;
              rw_d    = sh_q[0];
              busy_d  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (rw_q) begin
              state_d = RDATA;
              sh_d    = rd_cur;
              oe_d    = ~rd_cur[7];
            end else begin
              state_d = PTR;
              oe_d    = 1'b0;
            end
          end
        end
        PTR: begin
          if (rx_done) begin
            cnt_d   = 4'd0;
            ptr_d   = sh_q;
            state_d = PTR_ACK;
            oe_d    = 1'b1;
          end
        end
        PTR_ACK: begin
          if (scl_fall) begin
            state_d = WDATA;
            oe_d    = 1'b0;
          end
        end
        WDATA: begin
          if (rx_done) begin
            cnt_d   = 4'd0;
            state_d = WDATA_ACK;
            if (ptr_q < LAST) begin
              oe_d   = 1'b1;
              wstb_d = 1'b1;
              widx_d = ptr_q;
              wdat_d = sh_q;
              ptr_d  = ptr_inc;
            end
          end
        end
        WDATA_ACK: begin
          if (scl_fall) begin
            state_d = WDATA;
            oe_d    = 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = RDATA_ACK;
              oe_d    = 1'b0;
            end else begin
              sh_d = {sh_q[6:0], 1'b0};
              oe_d = ~sh_q[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) ack_d = ~sda_s;
          if (scl_fall) begin
            ptr_d = ptr_inc;
            cnt_d = 4'd0;
            if (ack_q) begin
              state_d = RDATA;
              sh_d    = rd_nxt;
              oe_d    = ~rd_nxt[7];
            end else begin
              state_d = IDLE;
              oe_d    = 1'b0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= 8'h00;
      ptr_q   <= 8'h00;
      rw_q    <= 1'b0;
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      wstb_q  <= 1'b0;
      widx_q  <= 8'h00;
      wdat_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      ack_q   <= ack_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      wstb_q  <= wstb_d;
      widx_q  <= widx_d;
      wdat_q  <= wdat_d;
    end
  end

  // Commit lands the cycle after the strobe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(REGCOUNT); i++) regs_q[i] <= 8'h00;
    end else if (wstb_q) begin
      for (int i = 0; i < int'(REGCOUNT); i++) begin
        if (widx_q == 8'(i)) regs_q[i] <= wdat_q;
      end
    end
  end

  for (genvar g = 0; g < int'(REGCOUNT); g++) begin : g_pack
    assign registers_packed[8*g +: 8] = regs_q[g];
  end

  assign sda_oe    = oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wstb_q;
  assign wr_index  = widx_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: bit-banged I2C controller against two targets on one bus.
// u_dut0 at 0x42 auto-increments, u_dut1 at 0x43 holds its pointer.
module tb_i2c_target_regfile;
  localparam int Q = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         scl;
  logic         sda_m;
  logic [7:0]   pin;
  logic         sda_line;
  logic         oe0, oe1;
  logic [159:0] regs0, regs1;
  logic         busy0, busy1;
  logic         stb0, stb1;
  logic [7:0]   idx0, idx1;

  int checks = 0;
  int fails  = 0;
  int stb_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] idx_log [$];
  logic [159:0] exp0 = '0;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~oe0 & ~oe1;

  i2c_target_regfile #(
    .REGCOUNT(20), .DEVADDR(7'h42), .AUTO_INC(1'b1)
  ) u_dut0 (
    .clock(clk), .reset(rst_n), .scl_in(scl), .sda_in(sda_line),
    .sda_oe(oe0), .parallel_in(pin), .registers_packed(regs0),
    .busy(busy0), .wr_strobe(stb0), .wr_index(idx0)
  );

  i2c_target_regfile #(
    .REGCOUNT(20), .DEVADDR(7'h43), .AUTO_INC(1'b0)
  ) u_dut1 (
    .clock(clk), .reset(rst_n), .scl_in(scl), .sda_in(sda_line),
    .sda_oe(oe1), .parallel_in(pin), .registers_packed(regs1),
    .busy(busy1), .wr_strobe(stb1), .wr_index(idx1)
  );

  always @(negedge clk) begin
    if (stb0) begin
      stb_cnt++;
      idx_log.push_back(idx0);
    end
    if (oe0) oe_cnt++;
    if (busy0) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [159:0] got,
                     input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic hq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic start_c();
    if (!scl) begin
      sda_m = 1'b1; hq();
      scl = 1'b1; hq();
    end
    sda_m = 1'b0; hq();
    scl = 1'b0; hq();
  endtask

  task automatic stop_c();
    sda_m = 1'b0; hq();
    scl = 1'b1; hq();
    sda_m = 1'b1; hq();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; hq();
      scl = 1'b1; hq();
      scl = 1'b0; hq();
    end
  endtask

  task automatic ack_bit(output logic a);
    sda_m = 1'b1; hq();
    scl = 1'b1; hq();
    a = ~sda_line;
    scl = 1'b0; hq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    send_bits(b);
    ack_bit(a);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic ack);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      hq();
      scl = 1'b1; hq();
      b[i] = sda_line;
      scl = 1'b0;
    end
    hq();
    sda_m = ~ack; hq();
    scl = 1'b1; hq();
    scl = 1'b0; hq();
    sda_m = 1'b1;
  endtask

  initial begin
    logic a0, a1, a2, a3;
    logic [7:0] d0, d1;
    int oc, bc, sc;
    rst_n = 1'b0;
    scl   = 1'b1;
    sda_m = 1'b1;
    pin   = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_oe", oe0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_stb", stb0, 1'b0);
    chk("rst_idx", idx0, 8'h00);
    chk("rst_regs", regs0, '0);
    rst_n = 1'b1;
    hq();

    // two-byte write from pointer 3
    start_c();
    send_byte(8'h84, a0);
    chk("t1_busy", busy0, 1'b1);
    send_byte(8'h03, a1);
    send_byte(8'hA5, a2);
    send_byte(8'h5A, a3);
    stop_c();
    exp0[8*3 +: 8] = 8'hA5;
    exp0[8*4 +: 8] = 8'h5A;
    chk("t1_acks", {a0, a1, a2, a3}, 4'b1111);
    chk("t1_reg3", regs0[8*3 +: 8], 8'hA5);
    chk("t1_reg4", regs0[8*4 +: 8], 8'h5A);
    chk("t1_nstb", stb_cnt, 2);
    chk("t1_idx0", idx_log[0], 8'h03);
    chk("t1_idx1", idx_log[1], 8'h04);
    chk("t1_busy_end", busy0, 1'b0);

    // reg19 written, next byte lands on pointer 20 and is refused
    start_c();
    send_byte(8'h84, a0);
    send_byte(8'h13, a1);
    send_byte(8'hC3, a2);
    send_byte(8'h99, a3);
    stop_c();
    exp0[8*19 +: 8] = 8'hC3;
    chk("t2p_acks", {a0, a1, a2, a3}, 4'b1110);
    chk("t2p_nstb", stb_cnt, 3);
    chk("t2p_regs", regs0, exp0);

    start_c();
    send_byte(8'h84, a0);
    send_byte(8'h00, a1);
    send_byte(8'h9C, a2);
    stop_c();
    exp0[8*0 +: 8] = 8'h9C;
    chk("t2q_acks", {a0, a1, a2}, 3'b111);
    chk("t2q_regs", regs0, exp0);

    // pointer write, repeated START, read reg19 then parallel_in
    pin = 8'h3C;
    start_c();
    send_byte(8'h84, a0);
    send_byte(8'h13, a1);
    start_c();
    send_byte(8'h85, a2);
    recv_byte(d0, 1'b1);
    recv_byte(d1, 1'b0);
    stop_c();
    chk("t2_acks", {a0, a1, a2}, 3'b111);
    chk("t2_rd0", d0, 8'hC3);
    chk("t2_rd1", d1, 8'h3C);
    start_c();
    send_byte(8'h85, a0);
    recv_byte(d0, 1'b0);
    stop_c();
    chk("t2_wrap", d0, 8'h9C);

    // address mismatch
    oc = oe_cnt;
    bc = busy_cnt;
    start_c();
    send_byte(8'h90, a0);
    send_byte(8'h55, a1);
    stop_c();
    chk("t3_ack", {a0, a1}, 2'b00);
    chk("t3_oe", oe_cnt - oc, 0);
    chk("t3_busy", busy_cnt - bc, 0);
    chk("t3_regs", regs0, exp0);

    // pointer past REGCOUNT
    sc = stb_cnt;
    start_c();
    send_byte(8'h84, a0);
    send_byte(8'h15, a1);
    send_byte(8'hFF, a2);
    stop_c();
    chk("t4_acks", {a0, a1, a2}, 3'b110);
    chk("t4_nstb", stb_cnt - sc, 0);
    chk("t4_regs", regs0, exp0);
    start_c();
    send_byte(8'h85, a0);
    recv_byte(d0, 1'b0);
    stop_c();
    chk("t4_rd", {a0, d0}, {1'b1, 8'h00});

    // pointer holds when AUTO_INC=0
    start_c();
    send_byte(8'h86, a0);
    send_byte(8'h02, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    stop_c();
    chk("t5_acks", {a0, a1, a2, a3}, 4'b1111);
    chk("t5_reg2", regs1[8*2 +: 8], 8'h22);
    chk("t5_reg3", regs1[8*3 +: 8], 8'h00);

    // reset during the address ACK
    start_c();
    send_bits(8'h84);
    sda_m = 1'b1;
    for (int k = 0; k < 40 && !oe0; k++) @(negedge clk);
    chk("t6_pre_oe", oe0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_oe", oe0, 1'b0);
    chk("t6_busy", busy0, 1'b0);
    chk("t6_regs", regs0, '0);
    chk("t6_idx", idx0, 8'h00);
    hq();
    rst_n = 1'b1;
    hq();
    scl = 1'b1; hq();
    scl = 1'b0; hq();
    oc = oe_cnt;
    send_byte(8'h84, a0);
    send_byte(8'h03, a1);
    send_byte(8'hAA, a2);
    stop_c();
    chk("t6_acks", {a0, a1, a2}, 3'b000);
    chk("t6_oe_post", oe_cnt - oc, 0);
    chk("t6_regs_post", regs0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 Parameter REGCOUNT SHALL default to 20: number of 8-bit read/write registers, range 1..254.
REQ-002 Parameter DEVADDR SHALL default to 7'h42: 7-bit I2C target address matched.
REQ-003 Parameter AUTO_INC SHALL default to 1: 1 = pointer increments after each data byte, 0 = pointer holds.
REQ-004 Port clock  input  1  system clock; all state on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 Port scl_in  input  1  raw I2C SCL, asynchronous to clock.
REQ-007 Port sda_in  input  1  raw I2C SDA, asynchronous to clock.
REQ-008 Port sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release.
REQ-009 Port parallel_in  input  8  external byte readable at pointer REGCOUNT.
REQ-010 Port registers_packed  output  8*REGCOUNT  register i at bits [8i+7:8i].
REQ-011 Port busy  output  1  high from address match until STOP/repeated START.
REQ-012 Port wr_strobe  output  1  one-cycle pulse on each committed register write.
REQ-013 Port wr_index  output  8  pointer of the last committed write; valid with wr_strobe.

Function
REQ-014 scl_in/sda_in SHALL pass through 2-flop synchronisers; all edge/condition detection uses synchronised values (2-cycle input latency).
REQ-015 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both SHALL be detected in any state.
REQ-016 States SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-017 START from any state -> ADDR, bit counter cleared; STOP from any state -> IDLE, sda_oe=0, busy=0.
REQ-018 Bits SHALL be sampled on synchronised SCL rising edge, MSB first; sda_oe SHALL change only on the cycle after a synchronised SCL falling edge.
REQ-019 ADDR: after 8 bits, address == DEVADDR -> ADDR_ACK (drive ACK), else IDLE with SDA released until next START.
REQ-020 ADDR_ACK with R/W=0 -> PTR; R/W=1 -> RDATA with shift register loaded from current pointer.
REQ-021 PTR: received byte loads pointer; ACK -> WDATA.
REQ-022 WDATA: pointer < REGCOUNT -> byte written, wr_strobe pulse, ACK; pointer >= REGCOUNT -> NACK, no write, registers unchanged.
REQ-023 RDATA read source: pointer < REGCOUNT -> register; pointer == REGCOUNT -> parallel_in sampled at byte load; pointer > REGCOUNT -> 8'h00.
REQ-024 RDATA_ACK: controller ACK (SDA low) -> reload next byte, RDATA; NACK -> IDLE-wait (SDA released) until STOP/START.
REQ-025 AUTO_INC=1: pointer increments after each ACKed write or read byte; wraps from REGCOUNT to 0 (pointer == REGCOUNT counts as last valid read location).
REQ-026 Pointer SHALL persist across transactions (write-pointer then repeated-START read supported).
REQ-027 Transaction aborted mid-byte by START/STOP SHALL commit nothing for the partial byte.
REQ-028 Host-side writes SHALL be the only register update path; registers_packed reflects a write on the cycle after wr_strobe.

Reset
REQ-029 reset=0 SHALL asynchronously clear: all registers to 8'h00, pointer to 0, state IDLE, sda_oe=0, busy=0, wr_strobe=0, wr_index=0, synchroniser flops to 1 (bus idle).
REQ-030 Reset assertion mid-transaction SHALL release SDA immediately; after release the block waits for a fresh START.

Verification
REQ-031 Write 0x84, ptr 0x03, data 0xA5, 0x5A, STOP -> ACK on all 4 bytes; reg3=0xA5, reg4=0x5A; two wr_strobe pulses, wr_index 3 then 4.
REQ-032 Write 0x84, ptr 0x13, repeated START, 0x85, read 2 bytes (ACK, NACK) with parallel_in=0x3C -> returns reg19 then 0x3C; pointer wraps to 0.
REQ-033 Address 0x90 (DEVADDR mismatch) -> no ACK, sda_oe stays 0, busy stays 0, no register change.
REQ-034 Write ptr 0x15 (REGCOUNT+1), data 0xFF -> address/pointer ACKed, data NACKed, no wr_strobe; subsequent read at 0x15 returns 0x00.
REQ-035 AUTO_INC=0: write ptr 0x02, data 0x11, 0x22 -> reg2=0x22, reg3 unchanged.
REQ-036 Drive reset=0 while sda_oe=1 during an ACK -> sda_oe=0 immediately, all registers 0x00; following transaction without START ignored.
